// File: rtl/fp_special_classify_pipe_if.sv
// Operand/result handshake bundle between the multiplier front end and the
// special-case classifier pipeline.
interface fp_special_classify_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_class_a;
    logic [2:0]   out_class_b;
    logic         out_bypass;
    logic [W-1:0] out_result;
    logic         out_sign;
    logic         flag_invalid;
    logic         flag_clr;

    modport master (
        output in_valid, in_a, in_b, out_ready, flag_clr,
        input  in_ready, out_valid, out_class_a, out_class_b,
               out_bypass, out_result, out_sign, flag_invalid
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, flag_clr,
        output in_ready, out_valid, out_class_a, out_class_b,
               out_bypass, out_result, out_sign, flag_invalid
    );
endinterface

// File: rtl/fp_special_classify_pipe.sv
// Two-stage IEEE-754 operand classifier and multiply special-case resolver
// with a sticky invalid-operation flag.
module fp_special_classify_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter bit DAZ    = 1'b0
) (
    input logic                       clk,
    input logic                       rst_n,
    fp_special_classify_pipe_if.slave bus
);
    localparam int W = 1 + EXP_W + FRAC_W;

    localparam logic [2:0] C_ZERO = 3'd0;
    localparam logic [2:0] C_SUB  = 3'd1;
    localparam logic [2:0] C_NORM = 3'd2;
    localparam logic [2:0] C_INF  = 3'd3;
    localparam logic [2:0] C_QNAN = 3'd4;
    localparam logic [2:0] C_SNAN = 3'd5;

    localparam logic [W-1:0] QUIET_BIT  = {{(EXP_W + 1){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};
    localparam logic [W-1:0] CANON_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W - 1){1'b0}}};

    function automatic logic [2:0] classify(input logic [W-1:0] v);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        logic [2:0]        c;
        e = v[W-2:FRAC_W];
        f = v[FRAC_W-1:0];
        if (&e) begin
            if (f == '0)
                c = C_INF;
            else if (f[FRAC_W-1])
                c = C_QNAN;
            else
                c = C_SNAN;
        end else if (e == '0) begin
            c = ((f == '0) || DAZ) ? C_ZERO : C_SUB;
        end else begin
            c = C_NORM;
        end
        return c;
    endfunction

    logic         r_s1Valid;
    logic [2:0]   r_s1ClassA;
    logic [2:0]   r_s1ClassB;
    logic         r_s1Sign;
    logic [W-1:0] r_s1A;
    logic [W-1:0] r_s1B;

    logic         r_s2Valid;
    logic [2:0]   r_s2ClassA;
    logic [2:0]   r_s2ClassB;
    logic         r_s2Sign;
    logic         r_s2Bypass;
    logic [W-1:0] r_s2Result;
    logic         r_s2Invalid;
    logic         r_flagInvalid;

    logic         w_adv1;
    logic         w_adv2;
    logic         w_aNan;
    logic         w_bNan;
    logic         w_infZero;
    logic         w_bypass;
    logic         w_invalid;
    logic [W-1:0] w_result;

    // Output stage moves when empty or drained; stage 1 also moves when stage 2 does.
    assign w_adv2       = ~r_s2Valid | bus.out_ready;
    assign w_adv1       = ~r_s1Valid | w_adv2;
    assign bus.in_ready = w_adv1;

    always_comb begin
        w_aNan    = (r_s1ClassA == C_QNAN) || (r_s1ClassA == C_SNAN);
        w_bNan    = (r_s1ClassB == C_QNAN) || (r_s1ClassB == C_SNAN);
        w_infZero = ((r_s1ClassA == C_INF) && (r_s1ClassB == C_ZERO)) ||
                    ((r_s1ClassB == C_INF) && (r_s1ClassA == C_ZERO));
        w_invalid = (r_s1ClassA == C_SNAN) || (r_s1ClassB == C_SNAN) || w_infZero;
        w_bypass  = 1'b1;
        w_result  = '0;
        if (w_aNan)
            w_result = r_s1A | QUIET_BIT;
        else if (w_bNan)
            w_result = r_s1B | QUIET_BIT;
        else if (w_infZero)
            w_result = CANON_QNAN;
        else if ((r_s1ClassA == C_INF) || (r_s1ClassB == C_INF))
            w_result = {r_s1Sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if ((r_s1ClassA == C_ZERO) || (r_s1ClassB == C_ZERO))
            w_result = {r_s1Sign, {(W - 1){1'b0}}};
        else
            w_bypass = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid  <= 1'b0;
            r_s1ClassA <= C_ZERO;
            r_s1ClassB <= C_ZERO;
            r_s1Sign   <= 1'b0;
            r_s1A      <= '0;
            r_s1B      <= '0;
        end else if (w_adv1) begin
            r_s1Valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1ClassA <= classify(bus.in_a);
                r_s1ClassB <= classify(bus.in_b);
                r_s1Sign   <= bus.in_a[W-1] ^ bus.in_b[W-1];
                r_s1A      <= bus.in_a;
                r_s1B      <= bus.in_b;
            end
        end
    end

    // Results hold while stalled; an emptied stage keeps its last payload harmlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2Valid   <= 1'b0;
            r_s2ClassA  <= C_ZERO;
            r_s2ClassB  <= C_ZERO;
            r_s2Sign    <= 1'b0;
            r_s2Bypass  <= 1'b0;
            r_s2Result  <= '0;
            r_s2Invalid <= 1'b0;
        end else if (w_adv2) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2ClassA  <= r_s1ClassA;
                r_s2ClassB  <= r_s1ClassB;
                r_s2Sign    <= r_s1Sign;
                r_s2Bypass  <= w_bypass;
                r_s2Result  <= w_result;
                r_s2Invalid <= w_invalid;
            end
        end
    end

    // Flag follows transferred results only; a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_flagInvalid <= 1'b0;
        else if (r_s2Valid && bus.out_ready && r_s2Invalid)
            r_flagInvalid <= 1'b1;
        else if (bus.flag_clr)
            r_flagInvalid <= 1'b0;
    end

    assign bus.out_valid    = r_s2Valid;
    assign bus.out_class_a  = r_s2ClassA;
    assign bus.out_class_b  = r_s2ClassB;
    assign bus.out_sign     = r_s2Sign;
    assign bus.out_bypass   = r_s2Bypass;
    assign bus.out_result   = r_s2Result;
    assign bus.flag_invalid = r_flagInvalid;
endmodule
